sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation controller; the driving end of the 8-bit `A >= B` magnitude comparator.
- It owns the comparator's B operand (`probe`) and reads back its `gte` flag.
- It binary-searches for the largest probe value with `gte = 1`, which equals the comparator's A operand.
- Used to digitise or recover an unknown value held on A (SAR-ADC style) in one bit per clock.

Parameters:
- WIDTH, 8, width of probe and result; must match the comparator operand width (≥1).

Ports:
- clk      input   1      system clock, rising-edge
- rst_n    input   1      asynchronous, active-low reset
- start    input   1      request a new search; sampled only in IDLE
- cmp_gte  input   1      comparator output: 1 when A >= probe; combinational, same cycle as probe
- probe    output  WIDTH  trial value driven to comparator B input
- busy     output  1      high while a search is in progress
- done     output  1      one-cycle pulse when result is valid
- result   output  WIDTH  search result; holds its value from done until the next accepted start

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- Reset (`rst_n = 0`, any time, including mid-search):
  - state ← IDLE, acc ← 0, bit_idx ← WIDTH-1.
  - probe = 0, busy = 0, done = 0, result = 0.
- States: IDLE, CONVERT, DONE (2-bit encoding).
- IDLE:
  - probe = 0, busy = 0.
  - When start = 1 at a clk edge: acc ← 0, bit_idx ← WIDTH-1, go to CONVERT.
- CONVERT:
  - busy = 1.
  - probe = acc | (1 << bit_idx), decoded from registers only; no combinational path from cmp_gte to probe.
  - Each clk edge: if cmp_gte, acc[bit_idx] ← 1, otherwise the bit stays 0.
  - If bit_idx = 0, go to DONE; otherwise bit_idx ← bit_idx - 1.
  - Exactly WIDTH cycles in CONVERT; the MSB is tried first.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, probe = 0.
  - Unconditionally return to IDLE.
- result = acc at all times.
  - It is only guaranteed correct from the DONE cycle onward.
  - It holds until the next accepted start clears acc.
- Latency: with start sampled at edge E0, CONVERT occupies cycles 1..WIDTH and done is high in cycle WIDTH+1 (cycle 9 for WIDTH = 8). Throughput is one search per WIDTH+2 cycles.
- start while in CONVERT or DONE is ignored: no restart, no queueing.
- start held high continuously produces back-to-back searches, one accepted per IDLE visit.
- Arithmetic: acc and probe are unsigned WIDTH bits; no carries. Probe values range over 1..2^WIDTH-1 during CONVERT.
- Boundary values:
  - A = 0: every trial gives gte = 0, so result = 0.
  - A = 2^WIDTH-1: every trial gives gte = 1, so result = all ones.
- A changing mid-search: the result is whatever the bitwise decisions produce. The FSM still completes in WIDTH cycles with no hang and no extra cycles.
- cmp_gte is ignored outside CONVERT.

Decomposition:
- Shared header: state encodings (S_IDLE = 2'd0, S_CONVERT = 2'd1, S_DONE = 2'd2). WIDTH defaults there as well.
- Single module, no sub-module.
- The comparator is not instantiated inside the block. The integrating top level wires probe→B and gte→cmp_gte; the bench does the same.

Test Plan:
- Reset, then start with A = 8'hA5 → probe sequence 80, C0, A0, B0, A8, A4, A6, A5. Then done = 1 in cycle 9 after the start edge, result = 8'hA5, busy high cycles 1..8 only.
- A = 8'h00 and A = 8'hFF in separate searches → result 8'h00 and 8'hFF respectively. Each done pulse lasts exactly one cycle.
- start pulsed again during CONVERT (cycle 4) with A = 8'h3C → ignored. result = 8'h3C at cycle 9, no second done.
- start held high for 30 cycles, A = 8'h81 → done pulses every 10 cycles. result = 8'h81 each time and holds between searches.
- rst_n driven low asynchronously mid-CONVERT (cycle 5) → immediately probe = 0, busy = 0, done = 0, result = 0. After release, a new search with A = 8'h5A yields 8'h5A.
- Sweep A over 0..255 with back-to-back searches → result == A for every value, compared against the comparator model.

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// default operand width and FSM state encodings.
package sar_search_pkg;

    localparam int SAR_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation controller: drives the B operand of an external
// A >= B comparator and binary-searches for A, one bit per clock, MSB first.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gte,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [IDX_W-1:0]   bit_idx;
    logic [WIDTH-1:0]   acc_next;

    function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Decision for the bit currently on trial; only consumed in CONVERT.
    assign acc_next = cmp_gte ? (acc | bit_mask(bit_idx)) : acc;

    assign result = acc;

    // probe is registered and precomputed one step ahead, so the comparator
    // sees it directly from a flop with no path back from cmp_gte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            bit_idx <= IDX_W'(WIDTH - 1);
            probe   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc     <= '0;
                        bit_idx <= IDX_W'(WIDTH - 1);
                        probe   <= bit_mask(IDX_W'(WIDTH - 1));
                        busy    <= 1'b1;
                        state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    acc <= acc_next;
                    if (bit_idx == '0) begin
                        probe <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                        probe   <= acc_next | bit_mask(bit_idx - 1'b1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    probe <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    probe <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a behavioural A >= B comparator closes the loop and a
// bit-by-bit binary-search model predicts probe values and results.
module tb_sar_search;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmp_gte;
    logic [W-1:0] probe;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] a_val;

    int checks = 0;
    int fails  = 0;

    sar_search #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmp_gte (cmp_gte),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // External comparator, wired as the integrating top level would.
    assign cmp_gte = (a_val >= probe);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a search on value a; returns the cycle (after the start edge) in
    // which done was first seen, or 99 if it never came.
    task automatic search(input logic [W-1:0] a, output logic [W-1:0] res, output int cyc);
        a_val = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!done) begin
            cyc = 99;
            $display("FAIL search_timeout a=%h no done within bound", a);
        end
        res = result;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || done) && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (probe !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            fails++;
            $display("FAIL reset_state probe=%h busy=%b done=%b result=%h required all zero",
                     probe, busy, done, result);
        end
    endtask

    // Full cycle-by-cycle check of one search against the binary-search model.
    task automatic check_search_trace(input logic [W-1:0] a, input string tag);
        logic [W-1:0] lo;
        logic [W-1:0] trial;
        a_val = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        lo = '0;
        for (int i = W - 1; i >= 0; i--) begin
            trial = lo + (W'(1) << i);
            checks++;
            if (probe !== trial || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s_probe bit=%0d probe=%h busy=%b done=%b required probe=%h busy=1 done=0",
                         tag, i, probe, busy, done, trial);
            end
            if (a >= trial) lo = trial;
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || probe !== 8'h00 || result !== a) begin
            fails++;
            $display("FAIL %s_done done=%b busy=%b probe=%h result=%h required done=1 busy=0 probe=00 result=%h",
                     tag, done, busy, probe, result, a);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== a) begin
            fails++;
            $display("FAIL %s_after done=%b busy=%b result=%h required done=0 busy=0 result=%h",
                     tag, done, busy, result, a);
        end
    endtask

    task automatic test_basic();
        check_search_trace(8'hA5, "basic");
    endtask

    task automatic test_bounds();
        logic [W-1:0] vals [2];
        logic [W-1:0] res;
        int cyc;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            search(vals[k], res, cyc);
            checks++;
            if (res !== vals[k] || cyc !== W + 1) begin
                fails++;
                $display("FAIL bounds_result a=%h result=%h cycle=%0d required result=%h cycle=%0d",
                         vals[k], res, cyc, vals[k], W + 1);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL bounds_pulse a=%h done=%b in following cycle required 0", vals[k], done);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt = 0;
        int first_done = 0;
        logic [W-1:0] res_at_done = '0;
        a_val = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = c;
                    res_at_done = result;
                end
            end
            tick();
        end
        checks++;
        if (done_cnt !== 1 || first_done !== W + 1 || res_at_done !== 8'h3C) begin
            fails++;
            $display("FAIL ignore_start done_count=%0d first_done=%0d result=%h required 1, %0d, 3c",
                     done_cnt, first_done, res_at_done, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        a_val = 8'h81;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                pulses++;
                checks++;
                if (c % (W + 2) != W + 1 || result !== 8'h81) begin
                    fails++;
                    $display("FAIL b2b_done cycle=%0d result=%h required cycle%%10=9 result=81", c, result);
                end
            end
            if (c % (W + 2) == 0) begin
                checks++;
                if (result !== 8'h81 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_hold cycle=%0d result=%h busy=%b required result=81 busy=0",
                             c, result, busy);
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (pulses !== 3) begin
            fails++;
            $display("FAIL b2b_pulses count=%0d required 3", pulses);
        end
        drain();
        tick();
    endtask

    task automatic test_async_reset();
        logic [W-1:0] res;
        int cyc;
        a_val = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (probe !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            fails++;
            $display("FAIL async_reset probe=%h busy=%b done=%b result=%h required all zero",
                     probe, busy, done, result);
        end
        #3;
        rst_n = 1'b1;
        tick();
        search(8'h5A, res, cyc);
        checks++;
        if (res !== 8'h5A || cyc !== W + 1) begin
            fails++;
            $display("FAIL async_reset_recover result=%h cycle=%0d required 5a, %0d", res, cyc, W + 1);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        for (int n = 0; n < 12; n++) begin
            a = W'($urandom_range(0, 255));
            check_search_trace(a, "random");
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] res;
        int cyc;
        for (int v = 0; v < 256; v++) begin
            search(W'(v), res, cyc);
            checks++;
            if (res !== W'(v) || cyc !== W + 1) begin
                fails++;
                $display("FAIL sweep a=%h result=%h cycle=%0d required result=%h cycle=%0d",
                         W'(v), res, cyc, W'(v), W + 1);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_val = '0;
        #2;
        test_reset();
        #20;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_bounds();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
